// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter states, slave select codes, default address
// width and the address region that decodes to no slave.
package bus_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_S1   = 2'b01;
  localparam logic [1:0] SEL_S2   = 2'b10;
  localparam logic [1:0] SEL_S3   = 2'b11;

  // Top-two-bit address region that has no slave behind it.
  localparam logic [1:0] REGION_ERR = 2'b11;

  // Map an address region onto the slave select driven to the slave muxes.
  function automatic logic [1:0] region_to_select(input logic [1:0] region);
    logic [1:0] sel;
    case (region)
      2'b00:   sel = SEL_S1;
      2'b01:   sel = SEL_S2;
      2'b10:   sel = SEL_S3;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: the top two address bits select a slave,
// the last region flags a decode error. Shared with the slave-side muxes.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        select,
  output logic              err
);

  logic [1:0] region;
  logic       unused_low_addr;

  // Only the region bits matter; the rest of the address belongs to the slave.
  assign region          = addr[ADDR_W-1 -: 2];
  assign unused_low_addr = ^addr[ADDR_W-3:0];

  // Region lookup; an error region yields no select.
  always_comb begin
    select = region_to_select(region);
    err    = (region == REGION_ERR);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with address decode and slave select.
// A tenure is ADDR (one cycle) followed by WAIT until the slave is ready.
// Optional feature macro: BUS_TIMEOUT_EN -- forces release of a tenure after
// TIMEOUT_CYCLES WAIT cycles without ready and pulses timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m1_req,
  input  logic              m2_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic              ready,
  output logic              m1_grant,
  output logic              m2_grant,
  output logic [1:0]        select,
  output logic              bus_busy,
  output logic              decode_err,
  output logic              timeout
);

  arb_state_t  state_reg, state_next;
  logic        m1_grant_reg, m1_grant_next;
  logic        m2_grant_reg, m2_grant_next;
  logic [1:0]  select_reg, select_next;
  logic        bus_busy_reg, bus_busy_next;
  logic        decode_err_reg, decode_err_next;
  logic        last_m2_reg, last_m2_next;   // 1: master 2 was granted last
  logic        release_now;
  logic        pick_m2;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]  dec_select;
  logic        dec_err;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_reg, timeout_next;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Round robin: with both requesting, the master not granted last wins.
  assign pick_m2  = m2_req && (!m1_req || !last_m2_reg);
  assign win_addr = pick_m2 ? m2_addr : m1_addr;

  bus_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr   (win_addr),
    .select (dec_select),
    .err    (dec_err)
  );

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_next      = state_reg;
    m1_grant_next   = m1_grant_reg;
    m2_grant_next   = m2_grant_reg;
    select_next     = select_reg;
    decode_err_next = 1'b0;
    last_m2_next    = last_m2_reg;
    release_now     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_next   = wait_cnt_reg;
    timeout_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (m1_req || m2_req) begin
          state_next      = ADDR;
          m1_grant_next   = !pick_m2;
          m2_grant_next   = pick_m2;
          select_next     = dec_select;
          decode_err_next = dec_err;
        end
      end
      ADDR: begin
        if (decode_err_reg) begin
          release_now = 1'b1;
        end else begin
          state_next = WAIT;
`ifdef BUS_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
        end
      end
      WAIT: begin
        // An unknown ready falls through to the hold path.
        if (ready) begin
          release_now = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wait_cnt_reg == CNT_LAST) begin
          release_now  = 1'b1;
          timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    if (release_now) begin
      state_next    = IDLE;
      m1_grant_next = 1'b0;
      m2_grant_next = 1'b0;
      select_next   = SEL_NONE;
      last_m2_next  = m2_grant_reg;
    end
    bus_busy_next = (state_next != IDLE);
  end

  // State and output registers; reset leaves master 1 with priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      m1_grant_reg   <= 1'b0;
      m2_grant_reg   <= 1'b0;
      select_reg     <= SEL_NONE;
      bus_busy_reg   <= 1'b0;
      decode_err_reg <= 1'b0;
      last_m2_reg    <= 1'b1;
    end else begin
      state_reg      <= state_next;
      m1_grant_reg   <= m1_grant_next;
      m2_grant_reg   <= m2_grant_next;
      select_reg     <= select_next;
      bus_busy_reg   <= bus_busy_next;
      decode_err_reg <= decode_err_next;
      last_m2_reg    <= last_m2_next;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // WAIT-cycle counter and the registered timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign m1_grant   = m1_grant_reg;
  assign m2_grant   = m2_grant_reg;
  assign select     = select_reg;
  assign bus_busy   = bus_busy_reg;
  assign decode_err = decode_err_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed steps followed by random
// traffic, all compared every cycle against a tenure-level reference model.
// Honors BUS_TIMEOUT_EN (timeout limit 4 when defined).
module tb_bus_arbiter;
  import bus_pkg::*;

`ifdef BUS_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, m1_req, m2_req, ready;
  logic [15:0] m1_addr, m2_addr;
  logic        m1_grant, m2_grant, bus_busy, decode_err, timeout;
  logic [1:0]  select;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, for how many grant cycles so far.
  int         m_owner = 0;   // 0 none, 1 master 1, 2 master 2
  int         m_last  = 2;
  int         m_age   = 0;
  logic [1:0] m_sel   = 2'b00;
  bit         m_err   = 1'b0;
  bit         m_to    = 1'b0;
  int         grant_log[$];

  bus_arbiter #(.ADDR_W(16), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req),
    .m1_addr(m1_addr), .m2_addr(m2_addr), .ready(ready),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .select(select),
    .bus_busy(bus_busy), .decode_err(decode_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_release(input bit to);
    $display("tenure: master=m%0d select=%02b grant_cycles=%0d decode_err=%0d timeout=%0d",
             m_owner, m_sel, m_age, m_err, to);
    m_last  = m_owner;
    m_owner = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic tick();
    int         w;
    logic [15:0] a;
    logic [1:0] region;
    @(posedge clk);
    m_to = 1'b0;
    if (!rst_n) begin
      if (m_owner != 0) $display("tenure: master=m%0d aborted by reset", m_owner);
      m_owner = 0;
      m_last  = 2;
    end else if (m_owner == 0) begin
      if (m1_req || m2_req) begin
        if (m1_req && m2_req) w = (m_last == 1) ? 2 : 1;
        else                  w = m1_req ? 1 : 2;
        a       = (w == 1) ? m1_addr : m2_addr;
        region  = a[15:14];
        m_err   = (region == 2'd3);
        m_sel   = m_err ? 2'b00 : 2'(region + 2'd1);
        m_owner = w;
        m_age   = 1;
        grant_log.push_back(w);
      end
    end else if (m_age == 1 && m_err) begin
      model_release(1'b0);
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (ready === 1'b1) begin
      model_release(1'b0);
    end else if (TO_EN && (m_age - 1) == TB_TO) begin
      m_to = 1'b1;
      model_release(1'b1);
    end else begin
      m_age++;
    end
    #1;
    chk("m1_grant",   8'(m1_grant),   8'(m_owner == 1));
    chk("m2_grant",   8'(m2_grant),   8'(m_owner == 2));
    chk("select",     8'(select),     8'((m_owner != 0) ? m_sel : 2'b00));
    chk("bus_busy",   8'(bus_busy),   8'(m_owner != 0));
    chk("decode_err", 8'(decode_err), 8'(m_owner != 0 && m_err && m_age == 1));
    chk("timeout",    8'(timeout),    8'(m_to));
  endtask

  initial begin
    // Reset held with both masters requesting.
    rst_n = 1'b0; m1_req = 1'b1; m2_req = 1'b1; ready = 1'b0;
    m1_addr = 16'h0000; m2_addr = 16'h8000;
    repeat (3) tick();
    chk("rst_busy", 8'(bus_busy), 8'd0);
    chk("rst_select", 8'(select), 8'd0);

    // First release: master 1 has priority; then contention alternates.
    rst_n = 1'b1;
    tick();
    chk("first_grant_m1", 8'(m1_grant), 8'd1);
    chk("first_select_s1", 8'(select), 8'(SEL_S1));
    ready = 1'b1;
    repeat (7) tick();
    m1_req = 1'b0; m2_req = 1'b0;
    repeat (2) tick();
    chk("contention_count", 8'(grant_log.size()), 8'd3);
    if (grant_log.size() == 3) begin
      chk("contention_g0", 8'(grant_log[0]), 8'd1);
      chk("contention_g1", 8'(grant_log[1]), 8'd2);
      chk("contention_g2", 8'(grant_log[2]), 8'd1);
    end

    // Single request to slave 2, ready after three WAIT cycles.
    ready = 1'b0; m1_req = 1'b1; m1_addr = 16'h4000;
    tick();
    chk("single_grant", 8'(m1_grant), 8'd1);
    chk("single_select", 8'(select), 8'(SEL_S2));
    m1_req = 1'b0;
    repeat (3) tick();
    chk("single_hold", 8'(select), 8'(SEL_S2));
    ready = 1'b1;
    tick();
    chk("single_done", 8'(m1_grant), 8'd0);
    ready = 1'b0;

    // Decode error from master 2.
    m2_req = 1'b1; m2_addr = 16'hC000;
    tick();
    chk("derr_grant", 8'(m2_grant), 8'd1);
    chk("derr_select", 8'(select), 8'(SEL_NONE));
    chk("derr_pulse", 8'(decode_err), 8'd1);
    m2_req = 1'b0;
    tick();
    chk("derr_idle", 8'(bus_busy), 8'd0);

    // Reset during WAIT.
    m1_req = 1'b1; m1_addr = 16'h8000;
    tick();
    m1_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_wait_busy", 8'(bus_busy), 8'd0);
    chk("rst_wait_grant", 8'(m1_grant), 8'd0);
    rst_n = 1'b1;
    tick();

    // Unknown ready while idle has no effect.
    ready = 1'bx;
    repeat (3) tick();
    chk("readyx_idle", 8'(bus_busy), 8'd0);
    ready = 1'b0;

`ifdef BUS_TIMEOUT_EN
    // Ready stuck low: forced release after four WAIT cycles.
    m2_req = 1'b1; m2_addr = 16'h0000;
    tick();
    m2_req = 1'b0;
    repeat (4) tick();
    chk("to_not_yet", 8'(timeout), 8'd0);
    tick();
    chk("to_pulse", 8'(timeout), 8'd1);
    chk("to_grant_drop", 8'(m2_grant), 8'd0);
    tick();
    chk("to_pulse_end", 8'(timeout), 8'd0);
    // Ready on the expiry cycle wins.
    m1_req = 1'b1; m1_addr = 16'h0000;
    tick();
    m1_req = 1'b0;
    repeat (4) tick();
    ready = 1'b1;
    tick();
    chk("to_ready_wins", 8'(timeout), 8'd0);
    chk("to_ready_release", 8'(m1_grant), 8'd0);
    ready = 1'b0;
`else
    // Without the timeout feature WAIT lasts until ready.
    m2_req = 1'b1; m2_addr = 16'h0000;
    tick();
    m2_req = 1'b0;
    repeat (30) tick();
    chk("nto_still_busy", 8'(bus_busy), 8'd1);
    chk("nto_no_pulse", 8'(timeout), 8'd0);
    ready = 1'b1;
    tick();
    chk("nto_release", 8'(bus_busy), 8'd0);
    ready = 1'b0;
`endif

    // Random traffic obeying the master request protocol.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_n = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 9);
      if (r < 4)      ready = 1'b1;
      else if (r < 9) ready = 1'b0;
      else            ready = 1'bx;
      if (m1_req) begin
        if (m_owner == 1 && m_age == 1 && $urandom_range(0, 1) == 1) m1_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        m1_req  = 1'b1;
        m1_addr = 16'($urandom);
      end
      if (m2_req) begin
        if (m_owner == 2 && m_age == 1 && $urandom_range(0, 1) == 1) m2_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        m2_req  = 1'b1;
        m2_addr = 16'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
